vector_loader: RTL
==================

# vector_loader

Serial-to-parallel input stage that sits directly upstream of `vector_reg`. It accepts one BITS-wide element per handshake from the host-facing byte or word stream and assembles N elements into a staging buffer. After the last element is accepted, it drives the complete vector and pulses `set` for one cycle so the downstream vector register captures all N lanes at once. It also provides `busy` and `done` status for the HAL.

## Interface

Parameters:
- `BITS`, 8, element width in bits.
- `N`, 64, elements per vector; N ≥ 2; index width is $clog2(N).

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a new load; single-cycle strobe.
- `in_data`  in  BITS  element value.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  loader accepts an element this cycle.
- `vec_out`  out  [BITS-1:0] x [N-1:0] unpacked  staging buffer; connects to `vector_reg.in`.
- `set`  out  1  one-cycle commit strobe; connects to `vector_reg.set`.
- `busy`  out  1  high in LOAD or COMMIT.
- `done`  out  1  sticky; high after a completed commit.

## Operation

- The state machine has three states: IDLE, LOAD and COMMIT.
- **IDLE**
  - `in_ready` = 0, and `in_valid` is ignored.
  - If `start` = 1, clear the index to 0, clear `done` and go to LOAD.
- **LOAD**
  - `in_ready` = 1.
  - An element is accepted when `in_valid` and `in_ready` are both high. On acceptance, write `buf[idx]` ← `in_data` and increment `idx`.
  - When the element accepted is the one at idx = N-1, go to COMMIT. `idx` wraps to 0.
  - `start` in LOAD aborts the load: `idx` ← 0 and the state stays LOAD.
    - Any accept in that same cycle is discarded and `in_ready` is forced to 0 for that cycle.
    - Buffer entries already written keep their values until overwritten. No `set` is issued.
- **COMMIT**
  - `set` = 1 and `in_ready` = 0 for exactly one cycle.
  - Next state is IDLE, and `done` ← 1.
  - `start` during COMMIT is ignored; the commit always completes.
- `vec_out[i]` is the `buf[i]` register directly. It is not gated or tri-stated; the output enable stays in `vector_reg`.
- `busy` = (state != IDLE).
- `done` stays high until the next accepted `start` or until reset.
- There is no arithmetic on data; elements pass through bit-exact.

## Timing

- Reset (asynchronous assert, `rst_n` = 0) forces all of the following:
  - state = IDLE, `idx` = 0, every `buf` entry = 0.
  - Outputs: `in_ready` = 0, `set` = 0, `busy` = 0, `done` = 0, every `vec_out` lane = 0.
- Reset mid-LOAD or mid-COMMIT has immediate effect. Any pending `set` is cancelled, and no partial vector is committed.
- Release is synchronous to `clk`, so the first `start` can be sampled at the first rising edge after `rst_n` goes high.
- `start` sampled at edge t gives state = LOAD and `in_ready` = 1 in cycle t+1.
- Elements are accepted on each edge where `in_valid` and `in_ready` are both high, at up to one element per cycle. `in_valid` gaps stall the loader without timeout.
- The last element accepted at edge k gives the following:
  - Cycle k+1: `set` = 1, with `vec_out` already holding all N new elements.
  - Cycle k+2: `set` = 0 and `done` = 1.
- `vector_reg` therefore captures at edge k+2.
- Minimum load time from `start` to `set` is N+1 cycles.
- `vec_out` is stable from the cycle `set` rises until the next accepted element.

## Test plan

- **Reset:** assert `rst_n` = 0 mid-operation → all outputs 0 immediately, and `in_ready` = 0 after release.
- **Back-to-back load (N=4, BITS=8):**
  - `start`, then elements 0x11, 0x22, 0x33, 0x44 on consecutive cycles → `vec_out` = {0x44,0x33,0x22,0x11} ([3]..[0]).
  - `set` is high for exactly one cycle, one cycle after 0x44 is accepted, and `done` = 1 the next cycle.
- **Stalled input:** same data with `in_valid` toggling 1,0,0,1,… → identical `vec_out`.
  - `set` occurs one cycle after the 4th accept and never earlier.
- **Abort:**
  - `start`, load 0xAA, 0xBB, then `start` again with `in_valid` = 1 in that cycle → that element is not accepted and `idx` returns to 0.
  - Then load 0x01..0x04 → `vec_out` = {0x04,0x03,0x02,0x01}, with a single `set`.
- **Ignored input:** `in_valid` = 1 with data 0xFF while IDLE → no accept and `vec_out` unchanged. A `start` pulse during COMMIT → `set` still one cycle, followed by IDLE.
- **Reset mid-LOAD:** pull `rst_n` low after 2 of 4 elements → no `set` pulse at any point.
  - After release, a full 4-element load commits the new values only.

Source files
------------

// File: rtl/vector_loader.sv
// -----------------------------------------------------------------------------
// vector_loader
//
// Serial-to-parallel input stage for vector_reg. Accepts one BITS-wide element
// per valid/ready handshake, assembles N of them in a staging buffer, then
// pulses `set` for one cycle so the downstream register captures every lane
// at once. Also provides busy/done status for the HAL.
//
// Ports:
//   clk       in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   single-cycle strobe; begins a load (or restarts one)
//   in_data   in   element value, BITS wide
//   in_valid  in   in_data is valid this cycle
//   in_ready  out  loader accepts an element this cycle
//   vec_out   out  staging buffer, N lanes of BITS (to vector_reg.in)
//   set       out  one-cycle commit strobe (to vector_reg.set)
//   busy      out  high while loading or committing
//   done      out  sticky; high after a completed commit
// -----------------------------------------------------------------------------
module vector_loader #(
    parameter int BITS = 8,
    parameter int N    = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [BITS-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [BITS-1:0] vec_out [N-1:0],
    output logic            set,
    output logic            busy,
    output logic            done
);

    localparam int               IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COMMIT
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [BITS-1:0]  stage_q [N-1:0];
    logic             done_q;
    logic             accept;

    // A start seen in LOAD is an abort: the element offered in that same
    // cycle must not be taken, so ready is withdrawn for that cycle.
    assign in_ready = (state_q == LOAD) && !start;
    assign accept   = in_valid && in_ready;
    assign set      = (state_q == COMMIT);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign vec_out  = stage_q;

    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: next-state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (accept && (idx_q == LAST)) state_d = COMMIT;
            // start is ignored here: a commit always runs to completion.
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write index and sticky done flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            if (start && (state_q != COMMIT)) begin
                idx_q <= '0;
            end else if (accept) begin
                idx_q <= (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
            end

            if (start && (state_q == IDLE)) begin
                done_q <= 1'b0;
            end else if (state_q == COMMIT) begin
                done_q <= 1'b1;
            end
        end
    end

    // NOTE: the staging buffer is reset because vec_out drives vector_reg
    // directly and must read all-zero after reset; an abort leaves written
    // lanes as they are.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= '0;
            end
        end else if (accept) begin
            stage_q[idx_q] <= in_data;
        end
    end

endmodule
